user_uart_tx: RTL and testbench
===============================

Name: user_uart_tx

Overview:
- Synthesizable UART transmitter for the toplevel `user_uart_rx` path; it is the far-end driver of that line.
- Replaces the bench's constant-1 tie-off so firmware receive paths can be exercised.
- Also usable as a core-side transmitter.
- Byte-wide valid/ready input, small FIFO, serializer emitting 8N1 frames at a fixed divider of the system clock.
- Line format is identical to what the bench UART monitor samples: 20 MHz clock, 10 Mbaud, LSB first.

Parameters:
- CLK_DIV, 1, clocks per bit minus one (bit period = CLK_DIV+1 clocks; 1 gives 10 Mbaud at 20 MHz).
- FIFO_DEPTH, 4, byte entries; power of two, at least 2.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept; a byte is accepted on an edge where tx_valid and tx_ready are both 1.
- uart_tx  out  1  serial line, idle high, registered output.
- tx_busy  out  1  frame in progress or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO.

Behaviour:
- Reset (reset_n=0 sampled at an edge):
  - uart_tx=1, tx_ready=1, tx_busy=0, fifo_level=0.
  - FIFO pointers cleared; FSM to IDLE; bit counter and divider counter cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high on the next edge.
- FIFO:
  - Push when tx_valid && tx_ready; tx_ready = (fifo_level != FIFO_DEPTH), combinational from registered level.
  - Pop only by the FSM in IDLE.
  - Push and pop on the same edge: both take effect and fifo_level is unchanged.
  - No bypass: a byte pushed into an empty FIFO is popped no earlier than the following edge.
  - Pointers wrap modulo FIFO_DEPTH.
- Divider: counter counts 0..CLK_DIV and reloads; each bit is held exactly CLK_DIV+1 clocks.
- FSM states are IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - uart_tx=1.
  - If FIFO non-empty: pop into the shift register, drive uart_tx=0, go to START, clear the divider.
  - Latency: byte accepted at edge N into an empty FIFO; pop at edge N+1; start bit visible from N+1.
- START: hold 0 for one bit period, then go to DATA with bit index 0.
- DATA:
  - uart_tx = shift[0] each bit period; shift right at the end of each bit.
  - After bit index 7 go to PARITY (if enabled) or STOP.
- STOP:
  - uart_tx=1 for STOP_BITS bit periods.
  - On the last clock of the stop period, if the FIFO is non-empty, pop and go directly to START.
  - Result: back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- Frame length is (10 + STOP_BITS - 1 [+1 parity]) × (CLK_DIV+1) clocks.
- tx_busy = (state != IDLE) || (fifo_level != 0).
- tx_data is sampled only at the push edge; later changes to tx_data do not affect queued bytes.

Optional Feature:
- Macro: USER_UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - Parity bit = XOR of the 8 data bits (even parity), held one bit period.
  - Frame grows by one bit.
- Undefined: no PARITY state and no parity logic; frames are pure 8N1/8N2.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding.
  - UART_DATA_W=8.
  - Frame-length constant function of STOP_BITS and the parity macro.
- One sub-module, user_uart_tx_fifo (parameterized FIFO_DEPTH, width 8), provides push, pop, level, full and empty.
- Serializer FSM and divider live in user_uart_tx.

Test Plan:
- Single byte: CLK_DIV=1, push 0x41 at edge N.
  - Response: uart_tx low at N+1 for 2 clocks; then bits 1,0,0,0,0,0,1,0 at 2 clocks each; stop high 2 clocks.
  - tx_busy drops 20 clocks after N+1.
  - A receiver sampling at mid-bit decodes 'A'.
- Back-to-back: push 0x55 then 0xAA on consecutive edges.
  - Response: the second start bit begins exactly 20 clocks after the first; no extra idle cycle.
  - Line pattern is alternating bits through frame 1.
- Full FIFO: hold tx_valid=1 with bytes 0x01..0x06 while the line is idle.
  - Response: first byte popped to the shifter; fifo_level reaches 4 and tx_ready=0.
  - Byte 0x06 is not accepted until the first stop completes.
  - Output order is 0x01..0x06.
- Reset mid-frame: push 0xF0, assert reset_n=0 during data bit 3.
  - Response: uart_tx=1 on the next edge and fifo_level=0.
  - After release, no residual frame is emitted.
- STOP_BITS=2: push 0x00.
  - Response: 9 bit-times low, then 2 bit-times high before tx_busy=0.
- USER_UART_TX_PARITY_EN defined: push 0x07.
  - Response: parity bit = 1 between data bit 7 and stop.
  - Frame is 22 clocks at CLK_DIV=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the user UART transmitter: data width, FSM encoding and frame length.
// Parity support is compiled in when USER_UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   // Serializer FSM encoding.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef USER_UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Bits per frame: start + data + optional parity + stop bits.
   function automatic int unsigned frame_bits(input int unsigned stop_bits);
      int unsigned n;
      n = 1 + UART_DATA_W + stop_bits;
`ifdef USER_UART_TX_PARITY_EN
      n = n + 1;
`endif
      return n;
   endfunction

endpackage

// File: rtl/user_uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer; registered level, pointers wrap modulo FIFO_DEPTH.
// FIFO_DEPTH must be a power of two, at least 2.
module user_uart_tx_fifo #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WIDTH      = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          push_i,
   input  logic [WIDTH-1:0]              wdata_i,
   input  logic                          pop_i,
   output logic [WIDTH-1:0]              rdata_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          full_o,
   output logic                          empty_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_push) begin
         mem_d[wptr_q] = wdata_i;
         wptr_d        = wptr_q + 1'b1;
      end
      if (do_pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage needs no reset; only entries below level are ever read.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/user_uart_tx.sv
// UART transmitter: valid/ready byte input, small FIFO, 8N1/8N2 serializer at CLK_DIV+1 clocks/bit.
// Define USER_UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module user_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 1,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                          clk_sys,
   input  logic                          reset_n,
   input  logic [UART_DATA_W-1:0]        tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          uart_tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned DIV_W   = (CLK_DIV == 0) ? 1 : $clog2(CLK_DIV + 1);
   localparam int unsigned IDX_W   = $clog2(UART_DATA_W);
   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV);
   localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(UART_DATA_W - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   logic [2:0]             state_q, state_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic                   tx_q, tx_d;
   logic                   stop_cnt_q, stop_cnt_d;
`ifdef USER_UART_TX_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [UART_DATA_W-1:0] fifo_rdata;
   logic                   bit_end;
   logic                   load;

   assign fifo_push = tx_valid && tx_ready;
   assign tx_ready  = !fifo_full;

   user_uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (UART_DATA_W)
   ) u_fifo (
      .clk_i   (clk_sys),
      .rst_ni  (reset_n),
      .push_i  (fifo_push),
      .wdata_i (tx_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bit_end = (div_q == DIV_MAX);
   assign uart_tx = tx_q;
   assign tx_busy = (state_q != ST_IDLE) || !fifo_empty;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      stop_cnt_d = stop_cnt_q;
      load       = 1'b0;
      fifo_pop   = 1'b0;
`ifdef USER_UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif

      if (state_q != ST_IDLE) begin
         div_d = bit_end ? '0 : div_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            tx_d  = 1'b1;
            div_d = '0;
            load  = !fifo_empty;
         end
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
               if (bit_idx_q == BIT_LAST) begin
`ifdef USER_UART_TX_PARITY_EN
                  state_d    = ST_PARITY;
                  tx_d       = parity_q;
`else
                  state_d    = ST_STOP;
                  tx_d       = 1'b1;
                  stop_cnt_d = 1'b0;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  tx_d      = shift_q[1];
               end
            end
         end
`ifdef USER_UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               state_d    = ST_STOP;
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               if (stop_cnt_q == STOP_LAST) begin
                  // Chain straight into the next frame when a byte is waiting.
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
                  load    = !fifo_empty;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (load) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_rdata;
         tx_d     = 1'b0;
         state_d  = ST_START;
         div_d    = '0;
`ifdef USER_UART_TX_PARITY_EN
         parity_d = ^fifo_rdata;
`endif
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         stop_cnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         stop_cnt_q <= stop_cnt_d;
      end
   end

`ifdef USER_UART_TX_PARITY_EN
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

endmodule

// File: tb/tb_user_uart_tx.sv
// Directed bench for user_uart_tx: one 8N1 instance and one 8N2 instance at CLK_DIV=1.
// Frame expectations include the parity bit when USER_UART_TX_PARITY_EN is defined.
module tb_user_uart_tx;

`ifdef USER_UART_TX_PARITY_EN
   localparam int FRAME_CLK = 22;
`else
   localparam int FRAME_CLK = 20;
`endif

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic [7:0] tx_data1, tx_data2;
   logic       tx_valid1, tx_valid2;
   logic       tx_ready1, tx_ready2;
   logic       uart_tx1, uart_tx2;
   logic       tx_busy1, tx_busy2;
   logic [2:0] fifo_level1, fifo_level2;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc01   = 0;
   int acc06   = 0;

   always #25 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   user_uart_tx #(.CLK_DIV(1), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .tx_data    (tx_data1),
      .tx_valid   (tx_valid1),
      .tx_ready   (tx_ready1),
      .uart_tx    (uart_tx1),
      .tx_busy    (tx_busy1),
      .fifo_level (fifo_level1)
   );

   user_uart_tx #(.CLK_DIV(1), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .tx_data    (tx_data2),
      .tx_valid   (tx_valid2),
      .tx_ready   (tx_ready2),
      .uart_tx    (uart_tx2),
      .tx_busy    (tx_busy2),
      .fifo_level (fifo_level2)
   );

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on the first clock of a start bit; returns on the first clock after the frame.
   task automatic run_frame(input bit sel, input logic [7:0] b, input int nstop);
      logic       fb [12];
      logic [7:0] dec;
      logic       line;
      int         nbits;
      dec   = '0;
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[1 + i] = b[i];
      nbits = 9;
`ifdef USER_UART_TX_PARITY_EN
      fb[9] = ^b;
      nbits = 10;
`endif
      for (int i = 0; i < nstop; i++) fb[nbits + i] = 1'b1;
      nbits = nbits + nstop;
      for (int k = 0; k < nbits * 2; k++) begin
         line = sel ? uart_tx2 : uart_tx1;
         check($sformatf("frame_%0h_dut%0d_clk%0d", b, sel + 1, k), 32'(line), 32'(fb[k / 2]));
         if ((k % 2 == 1) && (k / 2 >= 1) && (k / 2 <= 8)) dec[k / 2 - 1] = line;
         if (k == nbits * 2 - 1)
            check($sformatf("busy_in_frame_%0h", b), 32'(sel ? tx_busy2 : tx_busy1), 32'd1);
         tick();
      end
      check($sformatf("decode_%0h", b), 32'(dec), 32'(b));
   endtask

   initial begin
      reset_n   = 1'b0;
      tx_data1  = '0;
      tx_data2  = '0;
      tx_valid1 = 1'b0;
      tx_valid2 = 1'b0;
      tick();
      tick();
      check("rst_uart_tx", 32'(uart_tx1), 32'd1);
      check("rst_tx_ready", 32'(tx_ready1), 32'd1);
      check("rst_tx_busy", 32'(tx_busy1), 32'd0);
      check("rst_fifo_level", 32'(fifo_level1), 32'd0);
      reset_n = 1'b1;
      tick();

      // Single byte 'A': no bypass, start bit at N+1, busy clears 20 clocks later.
      tx_data1  = 8'h41;
      tx_valid1 = 1'b1;
      tick();
      tx_valid1 = 1'b0;
      check("single_level_after_push", 32'(fifo_level1), 32'd1);
      check("single_line_idle_at_push", 32'(uart_tx1), 32'd1);
      tick();
      check("single_level_after_pop", 32'(fifo_level1), 32'd0);
      check("single_busy", 32'(tx_busy1), 32'd1);
      run_frame(1'b0, 8'h41, 1);
      check("single_busy_done", 32'(tx_busy1), 32'd0);
      check("single_line_idle", 32'(uart_tx1), 32'd1);

      // Back-to-back: second start bit directly follows the first stop bit.
      tx_data1  = 8'h55;
      tx_valid1 = 1'b1;
      tick();
      tx_data1  = 8'hAA;
      tick();
      tx_valid1 = 1'b0;
      check("b2b_level", 32'(fifo_level1), 32'd1);
      run_frame(1'b0, 8'h55, 1);
      run_frame(1'b0, 8'hAA, 1);
      check("b2b_busy_done", 32'(tx_busy1), 32'd0);

      // Reset during data bit 3 of 0xF0 with a second byte queued.
      tx_data1  = 8'hF0;
      tx_valid1 = 1'b1;
      tick();
      tx_data1  = 8'h33;
      tick();
      tx_valid1 = 1'b0;
      repeat (8) tick();
      check("rst_mid_line_low", 32'(uart_tx1), 32'd0);
      check("rst_mid_level", 32'(fifo_level1), 32'd1);
      reset_n = 1'b0;
      tick();
      check("rst_mid_line_high", 32'(uart_tx1), 32'd1);
      check("rst_mid_level_clear", 32'(fifo_level1), 32'd0);
      check("rst_mid_busy", 32'(tx_busy1), 32'd0);
      check("rst_mid_ready", 32'(tx_ready1), 32'd1);
      reset_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         check($sformatf("rst_no_residual_clk%0d", k), 32'(uart_tx1), 32'd1);
      end
      check("rst_no_residual_busy", 32'(tx_busy1), 32'd0);

      // Two stop bits: 0x00 gives 9 bit-times low, then 2 high.
      tx_data2  = 8'h00;
      tx_valid2 = 1'b1;
      tick();
      tx_valid2 = 1'b0;
      tick();
      run_frame(1'b1, 8'h00, 2);
      check("stop2_busy_done", 32'(tx_busy2), 32'd0);

      // 0x07: parity bit 1 when parity is compiled in.
      tx_data1  = 8'h07;
      tx_valid1 = 1'b1;
      tick();
      tx_valid1 = 1'b0;
      tick();
      run_frame(1'b0, 8'h07, 1);
      check("p07_busy_done", 32'(tx_busy1), 32'd0);

      // Full FIFO: 0x01..0x06 streamed with tx_valid held high.
      fork
         begin : pusher
            bit done;
            for (int v = 1; v <= 6; v++) begin
               done      = 1'b0;
               tx_data1  = 8'(v);
               tx_valid1 = 1'b1;
               for (int w = 0; w < 100 && !done; w++) begin
                  done = tx_ready1;
                  tick();
               end
               check($sformatf("push_%0d_accepted", v), 32'(done), 32'd1);
               if (v == 1) acc01 = cyc;
               if (v == 6) acc06 = cyc;
               if (v == 5) begin
                  check("full_level", 32'(fifo_level1), 32'd4);
                  check("full_ready", 32'(tx_ready1), 32'd0);
               end
            end
            tx_valid1 = 1'b0;
         end
         begin : framer
            tick();
            tick();
            for (int f = 1; f <= 6; f++) run_frame(1'b0, 8'(f), 1);
         end
      join
      check("full_byte6_delay", 32'(acc06 - acc01), 32'(FRAME_CLK + 2));
      check("full_busy_done", 32'(tx_busy1), 32'd0);
      check("full_level_done", 32'(fifo_level1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
